toeplitz_row_gen: RTL and testbench

Parametrised Toeplitz row generator for the privacy-amplification hash datapath. It accepts a seed over a valid/ready handshake and streams N_ROWS successive ROW_W-bit windows of that seed, one window per accepted transfer, to the downstream row-sum/XOR accumulator. It adds the following to the fixed-size, free-running shifter: downstream backpressure, last/index tagging, a done pulse and abort.

---
 rtl/toeplitz_row_gen_if.sv | 28 ++
 rtl/toeplitz_row_gen.sv | 104 ++++++++++
 tb/tb_toeplitz_row_gen.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/toeplitz_row_gen_if.sv
// Seed-in / row-out stream bundle for toeplitz_row_gen.
// slave is the generator's view, master is the driver/consumer's view.
interface toeplitz_row_gen_if #(
    parameter int SEED_W = 7168,
    parameter int ROW_W  = 3072,
    parameter int N_ROWS = 4096
);
    localparam int IDX_W = $clog2(N_ROWS);

    logic [SEED_W-1:0] seed;
    logic              seed_valid;
    logic              seed_ready;
    logic [ROW_W-1:0]  row;
    logic              row_valid;
    logic              row_ready;
    logic [IDX_W-1:0]  row_idx;
    logic              row_last;

    modport master (
        output seed, seed_valid, row_ready,
        input  seed_ready, row, row_valid, row_idx, row_last
    );

    modport slave (
        input  seed, seed_valid, row_ready,
        output seed_ready, row, row_valid, row_idx, row_last
    );
endinterface

// File: rtl/toeplitz_row_gen.sv
// Toeplitz row generator: streams N_ROWS sliding ROW_W-bit windows
// of a captured seed with backpressure, last/index tags, done and abort.
module toeplitz_row_gen #(
    parameter int ROW_W  = 3072,
    parameter int N_ROWS = 4096,
    parameter int SEED_W = 7168
) (
    input  logic                clk_in,
    input  logic                rst,
    toeplitz_row_gen_if.slave   sif,
    output logic                busy,
    output logic                done,
    input  logic                abort
);
    localparam int IDX_W = $clog2(N_ROWS);

    if (SEED_W < ROW_W + N_ROWS - 1) begin : g_bad_seed_w
        $error("SEED_W must be >= ROW_W + N_ROWS - 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [SEED_W-1:0] cache;
    logic [IDX_W-1:0]  row_idx;
    logic              row_valid;
    logic              xfer;
    logic              last;

    assign last            = row_valid & (row_idx == IDX_W'(N_ROWS - 1));
    assign xfer            = row_valid & sif.row_ready;
    assign sif.seed_ready  = (state == IDLE) & ~rst;
    // The current window is always the top of the shifting cache.
    assign sif.row         = cache[SEED_W-1 -: ROW_W];
    assign sif.row_valid   = row_valid;
    assign sif.row_idx     = row_idx;
    assign sif.row_last    = last;
    assign busy            = (state != IDLE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (sif.seed_valid) state_nx = RUN;
            RUN: begin
                if (abort)             state_nx = IDLE;
                else if (xfer && last) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= IDLE;
            cache     <= '0;
            row_idx   <= '0;
            row_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sif.seed_valid) begin
                        cache     <= sif.seed;
                        row_idx   <= '0;
                        row_valid <= 1'b1;
                    end
                end
                RUN: begin
                    // Abort wins over a same-cycle transfer; that row is dropped.
                    if (abort) begin
                        cache     <= '0;
                        row_idx   <= '0;
                        row_valid <= 1'b0;
                    end else if (xfer) begin
                        if (last) begin
                            row_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            cache   <= cache << 1;
                            row_idx <= row_idx + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    cache   <= '0;
                    row_idx <= '0;
                end
                default: begin
                    cache     <= '0;
                    row_idx   <= '0;
                    row_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_toeplitz_row_gen.sv
// Directed bench for toeplitz_row_gen: small 8/4/11 instance
// plus a default-parameter instance fed a random 7168-bit seed.
module tb_toeplitz_row_gen;
    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_in = ~clk_in;

    toeplitz_row_gen_if #(.SEED_W(11), .ROW_W(8), .N_ROWS(4)) s_if ();
    logic s_busy, s_done, s_abort;

    toeplitz_row_gen #(.ROW_W(8), .N_ROWS(4), .SEED_W(11)) u_small (
        .clk_in (clk_in),
        .rst    (rst),
        .sif    (s_if.slave),
        .busy   (s_busy),
        .done   (s_done),
        .abort  (s_abort)
    );

    toeplitz_row_gen_if b_if ();
    logic b_busy, b_done, b_abort;

    toeplitz_row_gen u_big (
        .clk_in (clk_in),
        .rst    (rst),
        .sif    (b_if.slave),
        .busy   (b_busy),
        .done   (b_done),
        .abort  (b_abort)
    );

    logic [7:0] exp_rows [4];

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic accept(input logic [10:0] sd);
        s_if.seed       = sd;
        s_if.seed_valid = 1'b1;
        chk("accept_seed_ready", 32'(s_if.seed_ready), 32'd1);
        step();
        s_if.seed_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        chk("rst_seed_ready", 32'(s_if.seed_ready), 32'd0);
        chk("rst_row_valid", 32'(s_if.row_valid), 32'd0);
        chk("rst_row", 32'(s_if.row), 32'd0);
        chk("rst_idx", 32'(s_if.row_idx), 32'd0);
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_done", 32'(s_done), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_seed_ready", 32'(s_if.seed_ready), 32'd1);
    endtask

    task automatic test_basic();
        s_if.row_ready = 1'b1;
        accept(11'h59C);
        // Keep a different seed offered during RUN; it must be ignored.
        s_if.seed       = 11'h000;
        s_if.seed_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("basic_row", 32'(s_if.row), 32'(exp_rows[k]));
            chk("basic_idx", 32'(s_if.row_idx), 32'(k));
            chk("basic_valid", 32'(s_if.row_valid), 32'd1);
            chk("basic_last", 32'(s_if.row_last), (k == 3) ? 32'd1 : 32'd0);
            chk("basic_seed_ready", 32'(s_if.seed_ready), 32'd0);
            chk("basic_done_early", 32'(s_done), 32'd0);
            step();
        end
        s_if.seed_valid = 1'b0;
        chk("basic_done", 32'(s_done), 32'd1);
        chk("basic_done_valid", 32'(s_if.row_valid), 32'd0);
        chk("basic_done_seed_ready", 32'(s_if.seed_ready), 32'd0);
        chk("basic_done_busy", 32'(s_busy), 32'd1);
        step();
        chk("basic_done_pulse", 32'(s_done), 32'd0);
        chk("basic_idle_seed_ready", 32'(s_if.seed_ready), 32'd1);
        chk("basic_idle_busy", 32'(s_busy), 32'd0);
    endtask

    task automatic test_backpressure();
        s_if.row_ready = 1'b1;
        accept(11'h59C);
        chk("bp_row0", 32'(s_if.row), 32'hB3);
        step();
        s_if.row_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_row", 32'(s_if.row), 32'h67);
            chk("bp_hold_idx", 32'(s_if.row_idx), 32'd1);
            chk("bp_hold_valid", 32'(s_if.row_valid), 32'd1);
            step();
        end
        s_if.row_ready = 1'b1;
        chk("bp_release_row", 32'(s_if.row), 32'h67);
        step();
        chk("bp_resume_row", 32'(s_if.row), 32'hCE);
        chk("bp_resume_idx", 32'(s_if.row_idx), 32'd2);
        step();
        chk("bp_last_row", 32'(s_if.row), 32'h9C);
        chk("bp_last", 32'(s_if.row_last), 32'd1);
        chk("bp_no_done_yet", 32'(s_done), 32'd0);
        step();
        chk("bp_done", 32'(s_done), 32'd1);
        step();
        chk("bp_idle", 32'(s_if.seed_ready), 32'd1);
    endtask

    task automatic test_abort();
        s_if.row_ready = 1'b1;
        accept(11'h59C);
        step();
        step();
        chk("abort_pre_row", 32'(s_if.row), 32'hCE);
        s_abort = 1'b1;
        step();
        s_abort = 1'b0;
        chk("abort_valid", 32'(s_if.row_valid), 32'd0);
        chk("abort_row", 32'(s_if.row), 32'd0);
        chk("abort_idx", 32'(s_if.row_idx), 32'd0);
        chk("abort_done", 32'(s_done), 32'd0);
        chk("abort_seed_ready", 32'(s_if.seed_ready), 32'd1);
        chk("abort_busy", 32'(s_busy), 32'd0);
        accept(11'h7FF);
        for (int k = 0; k < 4; k++) begin
            chk("abort_new_row", 32'(s_if.row), 32'hFF);
            chk("abort_new_idx", 32'(s_if.row_idx), 32'(k));
            step();
        end
        chk("abort_new_done", 32'(s_done), 32'd1);
        step();
    endtask

    task automatic test_abort_last();
        s_if.row_ready = 1'b1;
        accept(11'h59C);
        step();
        step();
        step();
        chk("abl_pre_last", 32'(s_if.row_last), 32'd1);
        s_abort = 1'b1;
        step();
        s_abort = 1'b0;
        chk("abl_done", 32'(s_done), 32'd0);
        chk("abl_busy", 32'(s_busy), 32'd0);
        chk("abl_seed_ready", 32'(s_if.seed_ready), 32'd1);
        chk("abl_valid", 32'(s_if.row_valid), 32'd0);
        step();
        chk("abl_done_later", 32'(s_done), 32'd0);
    endtask

    task automatic test_reset_mid();
        s_if.row_ready = 1'b1;
        accept(11'h59C);
        step();
        chk("rmid_pre_row", 32'(s_if.row), 32'h67);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rmid_valid", 32'(s_if.row_valid), 32'd0);
        chk("rmid_row", 32'(s_if.row), 32'd0);
        chk("rmid_idx", 32'(s_if.row_idx), 32'd0);
        chk("rmid_last", 32'(s_if.row_last), 32'd0);
        chk("rmid_busy", 32'(s_busy), 32'd0);
        chk("rmid_done", 32'(s_done), 32'd0);
        accept(11'h59C);
        for (int k = 0; k < 4; k++) begin
            chk("rmid_new_row", 32'(s_if.row), 32'(exp_rows[k]));
            step();
        end
        chk("rmid_new_done", 32'(s_done), 32'd1);
        step();
    endtask

    task automatic test_default_params();
        logic [7167:0] bs;
        logic [3071:0] want;
        int            cyc;
        for (int i = 0; i < 224; i++) bs[i*32 +: 32] = $urandom;
        b_if.row_ready  = 1'b1;
        b_if.seed       = bs;
        b_if.seed_valid = 1'b1;
        chk("big_seed_ready", 32'(b_if.seed_ready), 32'd1);
        step();
        b_if.seed_valid = 1'b0;
        cyc = 1;
        for (int k = 0; k < 4096; k++) begin
            want = bs[7167-k -: 3072];
            checks++;
            if (b_if.row !== want || b_if.row_valid !== 1'b1 ||
                b_if.row_idx !== 12'(k)) begin
                errors++;
                $display("FAIL big_row k=%0d idx=%0d valid=%0b row_lsw=%0h required_lsw=%0h",
                         k, b_if.row_idx, b_if.row_valid, b_if.row[31:0], want[31:0]);
            end
            step();
            cyc++;
        end
        chk("big_done", 32'(b_done), 32'd1);
        chk("big_done_cycle", 32'(cyc), 32'd4097);
        step();
        chk("big_idle", 32'(b_if.seed_ready), 32'd1);
    endtask

    initial begin
        exp_rows[0] = 8'hB3;
        exp_rows[1] = 8'h67;
        exp_rows[2] = 8'hCE;
        exp_rows[3] = 8'h9C;
        s_if.seed       = '0;
        s_if.seed_valid = 1'b0;
        s_if.row_ready  = 1'b0;
        s_abort         = 1'b0;
        b_if.seed       = '0;
        b_if.seed_valid = 1'b0;
        b_if.row_ready  = 1'b0;
        b_abort         = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_abort_last();
        test_reset_mid();
        test_default_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
